// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between CPU loads/stores and the
// display scanout prefetch FIFO, with a starvation counter protecting the display.
module data_mem_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int SCREEN_BASE  = 16384,
    parameter int SCREEN_WORDS = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_adr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    output logic        mem_load,
    output logic [14:0] mem_adr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        frame_start,
    output logic [15:0] vid_word,
    output logic        vid_valid,
    input  logic        vid_ready,
    output logic        vid_underrun,
    output logic [1:0]  dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = $clog2(SCREEN_WORDS + 1);

    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   WORDS_C = (PW + 1)'(SCREEN_WORDS);
    localparam logic [PW-1:0] LAST_C  = PW'(SCREEN_WORDS - 1);
    localparam logic [PW-1:0] DONE_C  = PW'(SCREEN_WORDS);
    localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);
    localparam logic [14:0]   BASE_C  = 15'(SCREEN_BASE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        VID  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      starve_cnt, starve_nxt;
    logic [PW-1:0]   scan_ptr;
    logic [PW-1:0]   delivered;
    logic            active;
    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   fifo_count;
    logic [15:0]     cpu_dout_q;
    logic            cpu_ack_q;
    logic            underrun_q;

    logic            in_vid, cpu_pend, vid_pend, push, pop, underrun_cond;
    logic [CW:0]     fill_lvl;
    logic [PW:0]     ptr_lvl;

    assign in_vid   = (state == VID);
    // The fetch in flight counts against both FIFO space and remaining screen words.
    assign fill_lvl = {1'b0, fifo_count} + {{CW{1'b0}}, in_vid};
    assign ptr_lvl  = {1'b0, scan_ptr} + {{PW{1'b0}}, in_vid};

    assign cpu_pend = cpu_req & ~cpu_ack_q & (state != CPU);
    assign vid_pend = frame_start | (active & (fill_lvl < DEPTH_C) & (ptr_lvl < WORDS_C));

    // Video stream handshake: a word transfers on every clock edge where
    // vid_valid and vid_ready are both high; vid_word is stable until then.
    assign vid_valid = (fifo_count != '0);
    assign vid_word  = vid_valid ? fifo_mem[rd_ptr] : 16'h0000;
    assign push      = in_vid & ~frame_start;
    assign pop       = vid_valid & vid_ready & ~frame_start;

    assign underrun_cond = vid_ready & ~vid_valid & active & (delivered < DONE_C);

    assign cpu_dout     = cpu_dout_q;
    assign cpu_ack      = cpu_ack_q;
    assign vid_underrun = underrun_q;
    assign dbg_state    = state;

    always_comb begin
        state_nxt  = IDLE;
        starve_nxt = starve_cnt;
        if (vid_pend && (starve_cnt >= LIMIT_C)) begin
            state_nxt = VID;
        end else if (cpu_pend) begin
            state_nxt = CPU;
        end else if (vid_pend) begin
            state_nxt = VID;
        end
        if (frame_start || !vid_pend || (state_nxt == VID)) begin
            starve_nxt = 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        mem_load = 1'b0;
        mem_adr  = 15'd0;
        mem_din  = 16'h0000;
        case (state)
            CPU: begin
                mem_load = cpu_we;
                mem_adr  = cpu_adr;
                mem_din  = cpu_din;
            end
            VID: begin
                mem_adr = BASE_C + 15'(scan_ptr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            cpu_ack_q  <= 1'b0;
            cpu_dout_q <= 16'h0000;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            cpu_ack_q  <= (state == CPU);
            underrun_q <= underrun_cond;
            if ((state == CPU) && !cpu_we) begin
                cpu_dout_q <= mem_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_ptr   <= '0;
            delivered  <= '0;
            active     <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (frame_start) begin
            scan_ptr   <= '0;
            delivered  <= '0;
            active     <= 1'b1;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                scan_ptr <= scan_ptr + PW'(1);
                if (scan_ptr == LAST_C) begin
                    active <= 1'b0;
                end
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                delivered <= delivered + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_dout;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural memory, CPU driver task and
// scoreboard queues for CPU load data and the video word stream.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_adr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic        mem_load;
    logic [14:0] mem_adr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        frame_start;
    logic [15:0] vid_word;
    logic        vid_valid;
    logic        vid_ready;
    logic        vid_underrun;
    logic [1:0]  dbg_state;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_VID  = 2'd2;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] cpu_exp_q[$];

    logic [15:0] mem     [0:32767];
    bit          written [0:32767];

    data_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_adr      (cpu_adr),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .cpu_ack      (cpu_ack),
        .mem_load     (mem_load),
        .mem_adr      (mem_adr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .frame_start  (frame_start),
        .vid_word     (vid_word),
        .vid_valid    (vid_valid),
        .vid_ready    (vid_ready),
        .vid_underrun (vid_underrun),
        .dbg_state    (dbg_state)
    );

    // Clock and memory model: screen words hold (index+1), other words a hash of the address.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [14:0] a);
        if (a >= 15'd16384 && a < 15'd24576) return 16'(a - 15'd16384) + 16'd1;
        return {1'b0, a} ^ 16'h5A5A;
    endfunction

    assign mem_dout = written[mem_adr] ? mem[mem_adr] : init_val(mem_adr);

    always @(posedge clk) begin
        if (mem_load) begin
            mem[mem_adr]     <= mem_din;
            written[mem_adr] <= 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_do(input logic we, input logic [14:0] adr, input logic [15:0] din,
                          output int lat, output int ml_cyc, output logic [15:0] dout);
        cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_din = din;
        lat = 0; ml_cyc = 0; dout = 16'h0000;
        while (lat < 40) begin
            tick;
            lat++;
            if (mem_load) ml_cyc++;
            if (cpu_ack) break;
        end
        dout = cpu_dout;
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_din = 0;
        frame_start = 0; vid_ready = 0;
        repeat (3) tick;
        n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", cpu_ack); end
        n_vec++; if (cpu_dout !== 16'h0) begin n_err++; $display("FAIL reset_dout got %h want 0000", cpu_dout); end
        n_vec++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", vid_valid); end
        n_vec++; if (vid_word !== 16'h0) begin n_err++; $display("FAIL reset_word got %h want 0000", vid_word); end
        n_vec++; if (vid_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", vid_underrun); end
        n_vec++; if (mem_load !== 1'b0) begin n_err++; $display("FAIL reset_mem_load got %b want 0", mem_load); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        reset = 1'b0;
        tick;
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL post_reset_state got %0d want 0", dbg_state); end
    endtask

    task automatic test_cpu_store_load;
        int lat, ml;
        logic [15:0] d, wdat;
        logic [14:0] adr;
        cpu_do(1'b1, 15'd100, 16'h1234, lat, ml, d);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL store_latency got %0d want 2", lat); end
        n_vec++; if (ml !== 1) begin n_err++; $display("FAIL store_mem_load_cycles got %0d want 1", ml); end
        n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL ack_one_cycle got %b want 0", cpu_ack); end
        cpu_exp_q.push_back(16'h1234);
        cpu_do(1'b0, 15'd100, 16'h0000, lat, ml, d);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL load_latency got %0d want 2", lat); end
        n_vec++; if (ml !== 0) begin n_err++; $display("FAIL load_mem_load_cycles got %0d want 0", ml); end
        wdat = cpu_exp_q.pop_front();
        n_vec++; if (d !== wdat) begin n_err++; $display("FAIL load_data got %h want %h", d, wdat); end
        for (int i = 0; i < 6; i++) begin
            adr  = 15'($urandom_range(1000, 16000));
            wdat = 16'($urandom);
            cpu_do(1'b1, adr, wdat, lat, ml, d);
            cpu_exp_q.push_back(wdat);
            cpu_do(1'b0, adr, 16'h0000, lat, ml, d);
            wdat = cpu_exp_q.pop_front();
            n_vec++; if (d !== wdat) begin n_err++; $display("FAIL rand_load adr %0d got %h want %h", adr, d, wdat); end
        end
    endtask

    task automatic test_prefetch_fill;
        int vid_cyc;
        logic [15:0] w;
        vid_ready = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_vec++; if (dbg_state !== ST_VID) begin n_err++; $display("FAIL fill_first_vid got %0d want 2", dbg_state); end
        n_vec++; if (mem_adr !== 15'd16384) begin n_err++; $display("FAIL fill_first_adr got %0d want 16384", mem_adr); end
        n_vec++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL fill_valid_early got %b want 0", vid_valid); end
        vid_cyc = 1;
        tick;
        n_vec++; if (vid_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid got %b want 1", vid_valid); end
        n_vec++; if (vid_word !== 16'd1) begin n_err++; $display("FAIL fill_head got %h want 0001", vid_word); end
        for (int i = 0; i < 10; i++) begin
            if (dbg_state == ST_VID) vid_cyc++;
            tick;
        end
        n_vec++; if (vid_cyc !== 4) begin n_err++; $display("FAIL fill_vid_cycles got %0d want 4", vid_cyc); end
        n_vec++; if (vid_valid !== 1'b1) begin n_err++; $display("FAIL fill_full_valid got %b want 1", vid_valid); end
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        vid_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = exp_q.pop_front();
            n_vec++;
            if (vid_valid !== 1'b1 || vid_word !== w) begin
                n_err++; $display("FAIL fill_drain valid %b got %h want %h", vid_valid, vid_word, w);
            end
            tick;
        end
        vid_ready = 1'b0;
    endtask

    task automatic test_full_frame;
        int got, vid_cyc, late_ur, extra, cyc;
        logic [15:0] w;
        exp_q.delete();
        for (int i = 0; i < 8192; i++) exp_q.push_back(16'(i + 1));
        vid_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        got = 0; vid_cyc = 0; late_ur = 0; extra = 0; cyc = 0;
        while (got < 8192 && cyc < 12000) begin
            if (dbg_state == ST_VID) vid_cyc++;
            if (cyc == 1) begin
                n_vec++; if (vid_underrun !== 1'b1) begin n_err++; $display("FAIL start_underrun got %b want 1", vid_underrun); end
            end
            if (cyc == 2) begin
                n_vec++; if (vid_underrun !== 1'b0) begin n_err++; $display("FAIL start_underrun_end got %b want 0", vid_underrun); end
            end
            if (vid_valid) begin
                w = exp_q.pop_front();
                n_vec++;
                if (vid_word !== w) begin n_err++; $display("FAIL frame_word %0d got %h want %h", got, vid_word, w); end
                got++;
            end
            tick;
            cyc++;
        end
        for (int i = 0; i < 8; i++) begin
            if (vid_underrun) late_ur++;
            if (dbg_state == ST_VID) vid_cyc++;
            if (vid_valid) extra++;
            tick;
        end
        n_vec++; if (got !== 8192) begin n_err++; $display("FAIL frame_count got %0d want 8192", got); end
        n_vec++; if (vid_cyc !== 8192) begin n_err++; $display("FAIL frame_fetches got %0d want 8192", vid_cyc); end
        n_vec++; if (late_ur !== 0) begin n_err++; $display("FAIL frame_late_underrun got %0d want 0", late_ur); end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL frame_extra_words got %0d want 0", extra); end
    endtask

    task automatic test_starvation;
        int last_vid, max_gap, acks, dbl, unexp;
        logic prev_ack;
        logic [15:0] w;
        exp_q.delete();
        cpu_exp_q.delete();
        for (int i = 0; i < 400; i++) exp_q.push_back(16'(i + 1));
        cpu_we = 1'b0; cpu_adr = 15'd200; cpu_req = 1'b1;
        vid_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        last_vid = 0; max_gap = 0; acks = 0; dbl = 0; unexp = 0; prev_ack = 1'b0;
        for (int c = 1; c <= 204; c++) begin
            if (c == 201) cpu_req = 1'b0;
            if (dbg_state == ST_VID && c <= 200) begin
                if (c - last_vid > max_gap) max_gap = c - last_vid;
                last_vid = c;
            end
            if (dbg_state == ST_CPU) cpu_exp_q.push_back(init_val(15'd200));
            if (cpu_ack) begin
                acks++;
                if (prev_ack) dbl++;
                if (cpu_exp_q.size() == 0) unexp++;
                else begin
                    w = cpu_exp_q.pop_front();
                    n_vec++;
                    if (cpu_dout !== w) begin n_err++; $display("FAIL starve_load got %h want %h", cpu_dout, w); end
                end
            end
            prev_ack = cpu_ack;
            if (vid_valid) begin
                w = exp_q.pop_front();
                n_vec++;
                if (vid_word !== w) begin n_err++; $display("FAIL starve_vid_word got %h want %h", vid_word, w); end
            end
            tick;
        end
        n_vec++; if (max_gap > 9) begin n_err++; $display("FAIL starve_vid_gap got %0d want <=9", max_gap); end
        n_vec++; if (acks < 20) begin n_err++; $display("FAIL starve_cpu_acks got %0d want >=20", acks); end
        n_vec++; if (dbl !== 0) begin n_err++; $display("FAIL starve_back_to_back_ack got %0d want 0", dbl); end
        n_vec++; if (unexp !== 0) begin n_err++; $display("FAIL starve_unexpected_ack got %0d want 0", unexp); end
        n_vec++; if (cpu_exp_q.size() !== 0) begin n_err++; $display("FAIL starve_missing_ack got %0d want 0", cpu_exp_q.size()); end
        vid_ready = 1'b0;
    endtask

    task automatic test_frame_restart;
        int got;
        logic [15:0] w;
        exp_q.delete();
        vid_ready = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        repeat (3) tick;
        n_vec++; if (dbg_state !== ST_VID || mem_adr !== 15'd16387) begin
            n_err++; $display("FAIL restart_setup state %0d adr got %0d want 16387", dbg_state, mem_adr);
        end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_vec++; if (vid_valid !== 1'b0) begin n_err++; $display("FAIL restart_flush got %b want 0", vid_valid); end
        n_vec++; if (dbg_state !== ST_VID) begin n_err++; $display("FAIL restart_state got %0d want 2", dbg_state); end
        n_vec++; if (mem_adr !== 15'd16384) begin n_err++; $display("FAIL restart_adr got %0d want 16384", mem_adr); end
        for (int i = 1; i <= 10; i++) exp_q.push_back(16'(i));
        vid_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            if (vid_valid) begin
                w = exp_q.pop_front();
                n_vec++;
                if (vid_word !== w) begin n_err++; $display("FAIL restart_word %0d got %h want %h", got, vid_word, w); end
                got++;
            end
            tick;
        end
        n_vec++; if (got !== 10) begin n_err++; $display("FAIL restart_count got %0d want 10", got); end
        vid_ready = 1'b0;
    endtask

    task automatic test_reset_mid_cpu;
        vid_ready = 1'b0;
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 15'd300; cpu_din = 16'h5555;
        tick;
        n_vec++; if (dbg_state !== ST_CPU) begin n_err++; $display("FAIL rst_cpu_setup got %0d want 1", dbg_state); end
        reset = 1'b1;
        tick;
        n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ack got %b want 0", cpu_ack); end
        n_vec++; if (cpu_dout !== 16'h0) begin n_err++; $display("FAIL rst_cpu_dout got %h want 0000", cpu_dout); end
        n_vec++; if (vid_valid !== 1'b0 || vid_word !== 16'h0) begin
            n_err++; $display("FAIL rst_cpu_vid valid %b word got %h want 0000", vid_valid, vid_word);
        end
        n_vec++; if (vid_underrun !== 1'b0) begin n_err++; $display("FAIL rst_cpu_underrun got %b want 0", vid_underrun); end
        n_vec++; if (mem_load !== 1'b0 || mem_adr !== 15'd0) begin
            n_err++; $display("FAIL rst_cpu_mem load %b adr got %0d want 0", mem_load, mem_adr);
        end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_cpu_state got %0d want 0", dbg_state); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick;
        reset = 1'b0;
        repeat (2) tick;
        n_vec++; if (cpu_ack !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL rst_cpu_after ack %b state got %0d want 0", cpu_ack, dbg_state);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_din = 0;
        frame_start = 0; vid_ready = 0;
        test_reset;
        test_cpu_store_load;
        test_prefetch_fill;
        test_full_frame;
        test_starvation;
        test_frame_restart;
        test_reset_mid_cpu;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
